// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: LSU/DMA request controller driving one word-wide RAM port, with read-modify-write for sub-word stores
module dmem_access_ctrl #(
  parameter int MEM_AW = 23
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
  state_t state;
  logic we, uns, err;
  logic [1:0] size, lane;
  logic [31:0] wdata, ld_data, mask, merged;
  logic [15:0] half;
  logic [7:0] bval;
  assign req_ready = reset && state == IDLE;
  always_comb begin
    err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (req_addr >> (MEM_AW + 2)) != 32'd0;
    bval = 8'(mem_rdata >> {lane, 3'b000});
    half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = size == 2'b00 ? {{24{~uns & bval[7]}}, bval} :
              size == 2'b01 ? {{16{~uns & half[15]}}, half} : mem_rdata;
    mask = size == 2'b00 ? 32'hFF << {lane, 3'b000} : 32'hFFFF << {lane[1], 4'b0000};
    merged = (mem_rdata & ~mask) | ((size == 2'b00 ? {4{wdata[7:0]}} : {2{wdata[15:0]}}) & mask);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      mem_addr <= '0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      we <= 1'b0;
      uns <= 1'b0;
      size <= '0;
      lane <= '0;
      wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we <= req_we;
          size <= req_size;
          uns <= req_unsigned;
          lane <= req_addr[1:0];
          wdata <= req_wdata;
          rsp_rdata <= '0;
          rsp_err <= err;
          if (err) begin
            rsp_valid <= 1'b1;
            state <= RESP;
          end else begin
            // full-word stores skip the read; everything else reads first
            mem_addr <= req_addr[MEM_AW+1:2];
            mem_wdata <= req_wdata;
            mem_wr_en <= req_we && req_size == 2'b10;
            state <= req_we && req_size == 2'b10 ? WR : RD;
          end
        end
        RD: state <= CAP;
        CAP: if (we) begin
          mem_wdata <= merged;
          mem_wr_en <= 1'b1;
          state <= WR;
        end else begin
          rsp_rdata <= ld_data;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        WR: begin
          mem_wr_en <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: table vectors, corner sequences and random traffic against a byte-level memory model
module tb_dmem_access_ctrl;
  localparam int MEM_AW = 23;
  logic clock = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, mem_wr_en;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0] ram [256];
  logic [31:0] refm [256];
  int checks = 0, failures = 0;
  logic [31:0] r_rdata, r_waddr;
  logic r_err;
  int r_lat, r_nwr, r_wcyc;
  dmem_access_ctrl #(.MEM_AW(MEM_AW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (mem_wr_en) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return 8'((w >> (8 * k)) & 32'hFF);
  endfunction
  // memory seen as bytes; loads gather bytes, stores scatter them
  task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err, output int lat);
    int nb, base, idx;
    logic [31:0] w;
    nb = 1 << sz;
    base = int'(a % 4);
    idx = int'((a / 4) % 256);
    err = sz == 2'd3 || (a % nb) != 0 || longint'(a) >= (longint'(4) << MEM_AW);
    rd = 0;
    if (err) lat = 1;
    else if (we) begin
      lat = (sz == 2'd2) ? 2 : 4;
      w = refm[idx];
      for (int i = 0; i < nb; i++) begin
        w &= ~(32'hFF << (8 * (base + i)));
        w |= 32'(byte_of(wd, i)) << (8 * (base + i));
      end
      refm[idx] = w;
    end else begin
      lat = 3;
      for (int i = 0; i < nb; i++) rd |= 32'(byte_of(refm[idx], base + i)) << (8 * i);
      if (!uns && nb < 4 && rd[8 * nb - 1]) rd |= 32'hFFFF_FFFF << (8 * nb);
    end
  endtask
  task automatic wait_ready(input string name);
    int k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk({name, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
  endtask
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] wd);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    wait_ready("xact");
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    r_lat = 0; r_nwr = 0; r_wcyc = 0; r_waddr = 0; r_rdata = 32'hx; r_err = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      if (mem_wr_en) begin
        r_nwr++;
        r_wcyc = c;
        r_waddr = 32'(mem_addr);
      end
      if (rsp_valid) begin
        r_lat = c;
        r_rdata = rsp_rdata;
        r_err = rsp_err;
        break;
      end
      @(negedge clock);
    end
  endtask
  task automatic apply(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat);
    logic [31:0] mrd;
    logic merr;
    int mlat;
    xact(we, sz, uns, a, wd);
    model(we, sz, uns, a, wd, mrd, merr, mlat);
    chk({tag, "_rdata"}, r_rdata, erd);
    chk({tag, "_err"}, {31'd0, r_err}, {31'd0, eerr});
    chk({tag, "_latency"}, r_lat, elat);
    chk({tag, "_wr_count"}, r_nwr, (we && !eerr) ? 1 : 0);
    if (we && !eerr) begin
      chk({tag, "_wr_cycle"}, r_wcyc, elat - 1);
      chk({tag, "_wr_addr"}, r_waddr, a >> 2);
      chk({tag, "_ram_word"}, ram[(a >> 2) % 256], refm[(a >> 2) % 256]);
    end
  endtask
  typedef struct {
    logic we; logic [1:0] sz; logic uns; logic [31:0] a; logic [31:0] wd;
    logic [31:0] rd; logic err; int lat;
  } vec_t;
  vec_t tbl[18];
  initial begin
    logic [31:0] mrd, a, wd;
    logic merr, we, uns;
    logic [1:0] sz;
    int mlat, ready_c, rsp_c, bad;
    for (int i = 0; i < 256; i++) begin ram[i] = 0; refm[i] = 0; end
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h102, 32'h5A, 32'h0, 1'b0, 4};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDE5ABEEF, 1'b0, 3};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h0000005A, 1'b0, 3};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 3};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h000000DE, 1'b0, 3};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 32'h0, 1'b0, 4};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h1234BEEF, 1'b0, 3};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'hFFFFBEEF, 1'b0, 3};
    tbl[10] = '{1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h0000BEEF, 1'b0, 3};
    tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h00001234, 1'b0, 3};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1};
    tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h103, 32'hFFFF, 32'h0, 1'b1, 1};
    tbl[14] = '{1'b1, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h0200_0000, 32'h0, 32'h0, 1'b1, 1};
    tbl[16] = '{1'b1, 2'd2, 1'b0, 32'h0200_0100, 32'h11111111, 32'h0, 1'b1, 1};
    tbl[17] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h1234BEEF, 1'b0, 3};
    repeat (3) @(negedge clock);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_outputs", {29'd0, rsp_valid, rsp_err, mem_wr_en}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    foreach (tbl[i])
      apply($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd,
            tbl[i].rd, tbl[i].err, tbl[i].lat);
    // SB with req_valid held high; a second (load) request waits behind it
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h109; req_wdata = 32'hC3;
    wait_ready("busy_sb");
    model(1'b1, 2'd0, 1'b0, 32'h109, 32'hC3, mrd, merr, mlat);
    @(posedge clock);
    @(negedge clock);
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h108;
    ready_c = 0; rsp_c = 0;
    for (int c = 1; c <= 10; c++) begin
      if (rsp_valid) rsp_c = c;
      if (req_ready) begin ready_c = c; break; end
      @(negedge clock);
    end
    chk("busy_rsp_cycle", rsp_c, 4);
    chk("busy_first_ready", ready_c, 5);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    model(1'b0, 2'd2, 1'b0, 32'h108, 32'h0, mrd, merr, mlat);
    rsp_c = 0;
    for (int c = 1; c <= 10; c++) begin
      if (rsp_valid) begin rsp_c = c; r_rdata = rsp_rdata; break; end
      @(negedge clock);
    end
    chk("busy_lw_latency", rsp_c, 3);
    chk("busy_lw_rdata", r_rdata, mrd);
    // reset asserted while the SB sits in CAP
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h10D; req_wdata = 32'hAB;
    wait_ready("abort_sb");
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_outputs", {29'd0, rsp_valid, rsp_err, mem_wr_en}, 32'd0);
    chk("abort_ready_low", {31'd0, req_ready}, 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (mem_wr_en || rsp_valid) bad++;
    end
    chk("abort_no_activity", bad, 0);
    chk("abort_ready_back", {31'd0, req_ready}, 32'd1);
    chk("abort_ram_word", ram[8'h43], refm[8'h43]);
    // random traffic against the byte-level model
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0200_0000) : 32'($urandom_range(0, 1023));
      wd = $urandom;
      refm_peek: begin
        logic [31:0] save [256];
        save = refm;
        model(we, sz, uns, a, wd, mrd, merr, mlat);
        refm = save;
      end
      apply($sformatf("rnd%0d", i), we, sz, uns, a, wd, mrd, merr, mlat);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side controller that drives one port of the dual-port data memory on behalf of the load/store unit.
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-addressed RAM port accesses.
- The RAM has no byte enables, so sub-word stores use read-modify-write.
- Returns aligned, sign- or zero-extended load data, or an error for misaligned and out-of-range requests.
- One instance per RAM port: port A for the core LSU, port B for DMA.

Parameters:
- MEM_AW, 23, RAM word-address width. Byte addresses use bits [MEM_AW+1:0].

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word; 11=illegal.
- req_unsigned  in  1  zero-extend load data (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  single-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  request rejected, valid with rsp_valid.
- mem_addr  out  MEM_AW  to RAM addr_bus.
- mem_wr_en  out  1  to RAM wr_en.
- mem_wdata  out  32  to RAM data_in.
- mem_rdata  in  32  from RAM data_out; registered, 1-cycle read latency.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: clock and reset sampled at posedge.
- Reset values: state=IDLE; mem_addr=0, mem_wr_en=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=0 while reset is low.
- Handshake: accept on req_valid&&req_ready at posedge. All request fields are latched. req_valid while busy is ignored; no queueing.
- Errors, checked at accept:
  - req_size=11.
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr[31:MEM_AW+2] nonzero.
  - Action: next state RESP with rsp_err=1 and rsp_rdata=0. No RAM access; mem_wr_en stays 0.
- Word address: mem_addr = addr[MEM_AW+1:2]. Byte lane = addr[1:0].
- FSM states: IDLE, RD, CAP, WR, RESP.
  - IDLE: req_ready=1. On accept:
    - error → RESP.
    - SW → WR.
    - load, SB or SH → RD.
  - RD: drive mem_addr with mem_wr_en=0; the RAM registers the word → CAP.
  - CAP: mem_rdata valid.
    - Load: extract the lane, extend it, latch rsp_rdata → RESP.
    - SB/SH: merge req_wdata[7:0] or [15:0] into the lane, latch mem_wdata → WR.
  - WR: mem_wr_en=1 for exactly one cycle, with mem_addr and mem_wdata stable → RESP.
  - RESP: rsp_valid=1 for one cycle → IDLE. The consumer must take the pulse; there is no backpressure.
- Latency, with accept at cycle T, as rsp_valid cycle:
  - error: T+1.
  - SW: T+2.
  - load: T+3.
  - SB/SH: T+4.
  - Back-to-back: next accept at rsp cycle+1.
- Extension:
  - Byte: lane = addr[1:0]×8.
  - Half: lane = addr[1]×16.
  - Signed: replicate the MSB of the lane. Unsigned: zero-fill.
  - Word loads ignore req_unsigned.
- mem_wr_en is 0 in every state except WR. mem_addr holds its last value in IDLE.
- Reset mid-operation (any state): return to IDLE with all outputs at reset values. A pending write is dropped (no mem_wr_en) and no response is issued.
- The RMW is not atomic against the other RAM port. Software/DMA ownership rules guarantee exclusive access to a word during sub-word stores; this block does not lock.

Test Plan:
1. Reset, then SW 0xDEADBEEF @0x100 → mem_wr_en=1 only at T+1 with mem_addr=0x40, mem_wdata=0xDEADBEEF; rsp_valid at T+2, rsp_err=0, rsp_rdata=0.
2. LW @0x100 → RD at T+1 with mem_wr_en=0; rsp_valid at T+3 with rsp_rdata=0xDEADBEEF.
3. SB 0x5A @0x102 → RAM word becomes 0xDE5ABEEF, rsp at T+4. Then:
   - LB @0x102 → 0x0000005A.
   - LB @0x103 → 0xFFFFFFDE.
   - LBU @0x103 → 0x000000DE.
4. SH 0x1234 @0x102 → word 0x1234BEEF. Then:
   - LH @0x100 → 0xFFFFBEEF.
   - LHU @0x100 → 0x0000BEEF.
   - LH @0x102 → 0x00001234.
5. Errors, each → rsp_err=1 at T+1, rsp_rdata=0, mem_wr_en never high, memory unchanged:
   - LW @0x101.
   - SH @0x103.
   - req_size=11.
   - LW @0x0200_0000.
6. Busy and reset-abort:
   - Hold req_valid high through an SB → req_ready=0 until IDLE, and the second request is accepted only after rsp_valid.
   - Assert reset during CAP of an SB → no mem_wr_en, no rsp_valid, IDLE with outputs 0 after release, RAM word unchanged.
